// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with first-word-fall-through output, any depth >= 2.
// Optional peak-level watermark output enabled by defining FIFO_WATERMARK_EN.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_WATERMARK_EN
  output logic [CNT_W-1:0]      max_level,
`endif
  output logic [CNT_W-1:0]      level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] level_nxt;
  logic             overflow_nxt, underflow_nxt;
  logic             push, pop;

  assign push = wr_en & (~full | rd_en);
  assign pop  = rd_en & ~empty;

  assign full         = (level == FULL_LVL);
  assign empty        = (level == '0);
  assign valid        = ~empty;
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);
  assign data_out     = mem[rd_ptr];

  // Explicit compare-and-clear wrap keeps non-power-of-two depths correct.
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    level_nxt     = level;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    if (clr) begin
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      level_nxt     = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else begin
      if (push) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      level_nxt = level + 1'b1;
      else if (pop && !push) level_nxt = level - 1'b1;
      if (wr_en && !push) overflow_nxt  = 1'b1;
      if (rd_en && empty) underflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

  // Storage has no reset; flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_WATERMARK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     max_level <= '0;
    else if (clr)                   max_level <= '0;
    else if (level_nxt > max_level) max_level <= level_nxt;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft at DEPTH=5 (AF=4, AE=1).
// Covers max_level too when FIFO_WATERMARK_EN is defined.
module tb_sync_fifo_fwft;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0] level;
  logic          overflow, underflow;
`ifdef FIFO_WATERMARK_EN
  logic [CW-1:0] max_level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .valid        (valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_WATERMARK_EN
    .max_level    (max_level),
`endif
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input int lvl, input logic ov, input logic un);
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
    check({tag, ".valid"}, 32'(valid), 32'(lvl != 0));
    check({tag, ".full"}, 32'(full), 32'(lvl == DEPTH));
    check({tag, ".af"}, 32'(almost_full), 32'(lvl >= 4));
    check({tag, ".ae"}, 32'(almost_empty), 32'(lvl <= 1));
    check({tag, ".ovf"}, 32'(overflow), 32'(ov));
    check({tag, ".udf"}, 32'(underflow), 32'(un));
  endtask

  // Apply one cycle of inputs, sample 1 time unit after the rising edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    wr_en = w; data_in = d; rd_en = r; clr = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; data_in = '0;
  endtask

  initial begin
    #3;
    check_status("reset", 0, 1'b0, 1'b0);
`ifdef FIFO_WATERMARK_EN
    check("reset.max", 32'(max_level), 32'd0);
`endif
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: fill, overflow, drain in order
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
      check_status($sformatf("t1.fill%0d", i), i + 1, 1'b0, 1'b0);
      check("t1.head", 32'(data_out), 32'h11);
    end
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check_status("t1.ovf", 5, 1'b1, 1'b0);
    check("t1.ovf_head", 32'(data_out), 32'h11);
`ifdef FIFO_WATERMARK_EN
    check("t1.max", 32'(max_level), 32'd5);
`endif
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1.pop%0d", i), 32'(data_out), 32'h11 + 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_status($sformatf("t1.drain%0d", i), 4 - i, 1'b1, 1'b0);
    end

    // T2: single-word fall-through latency
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check_status("t2.push", 1, 1'b1, 1'b0);
    check("t2.data", 32'(data_out), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("t2.pop", 0, 1'b1, 1'b0);

    // T3: flush, refill, then simultaneous push/pop while full across wrap
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_status("t3.clr", 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
    check_status("t3.full", 5, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t3.head%0d", i), 32'(data_out),
            (i < 5) ? 32'h21 + 32'(i) : 32'h30 + 32'(i - 5));
      step(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
      check_status($sformatf("t3.rw%0d", i), 5, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3.tail%0d", i), 32'(data_out), 32'h32 + 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check_status("t3.empty", 0, 1'b0, 1'b0);

    // T4: pop on empty with simultaneous push; no same-cycle bypass
    wr_en = 1'b1; data_in = 8'h3C; rd_en = 1'b1;
    #1;
    check("t4.nobypass", 32'(valid), 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    check_status("t4", 1, 1'b0, 1'b1);
    check("t4.data", 32'(data_out), 32'h3C);

    // T5: clr beats a concurrent write and clears sticky flags
    for (int i = 0; i < 4; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_status("t5.pre", 3, 1'b1, 1'b1);
    check("t5.pre_head", 32'(data_out), 32'h42);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    check_status("t5.clr", 0, 1'b0, 1'b0);
`ifdef FIFO_WATERMARK_EN
    check("t5.max", 32'(max_level), 32'd0);
`endif
    step(1'b1, 8'h55, 1'b0, 1'b0);
    check_status("t5.post", 1, 1'b0, 1'b0);
    check("t5.post_data", 32'(data_out), 32'h55);
`ifdef FIFO_WATERMARK_EN
    check("t5.max1", 32'(max_level), 32'd1);
`endif

    // T6: async reset mid-operation takes effect without a clock edge
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b1, 8'h67, 1'b1, 1'b0);
    check_status("t6.pre", 2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_status("t6.rst", 0, 1'b0, 1'b0);
`ifdef FIFO_WATERMARK_EN
    check("t6.max", 32'(max_level), 32'd0);
`endif
    #1 rst_n = 1'b1;
    step(1'b1, 8'h88, 1'b0, 1'b0);
    check_status("t6.after", 1, 1'b0, 1'b0);
    check("t6.data", 32'(data_out), 32'h88);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
